// File: rtl/chip8_fb_pkg.sv
// Shared definitions for the Chip8 framebuffer write side.
// Contents:
//   FB_W, FB_H, FB_BITS : framebuffer geometry (64 x 32 = 2048 bits)
//   state_t             : sprite drawer FSM states
//   fb_index(row, col)  : flat framebuffer bit index, row*64 + col
package chip8_fb_pkg;

    localparam int FB_W    = 64;
    localparam int FB_H    = 32;
    localparam int FB_BITS = FB_W * FB_H;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAW  = 3'd2,
        S_CLEAR = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [10:0] fb_index(input logic [4:0] row, input logic [5:0] col);
        return 11'(row) * 11'(FB_W) + 11'(col);
    endfunction

endpackage

// File: rtl/chip8_row_xor.sv
// Combinational XOR of one 8-pixel sprite byte into one 64-pixel framebuffer row.
// Ports:
//   i_old_row   in  64  current row contents, bit = column
//   i_byte      in  8   sprite byte, bit 7 is the leftmost pixel
//   i_x         in  6   starting column (already reduced mod 64)
//   i_clip_mask in  8   bit k enables sprite pixel k (k=0 is leftmost)
//   o_new_row   out 64  row after XOR
//   o_hit       out 1   some enabled sprite pixel landed on a lit pixel
module chip8_row_xor
    import chip8_fb_pkg::*;
(
    input  logic [FB_W-1:0] i_old_row,
    input  logic [7:0]      i_byte,
    input  logic [5:0]      i_x,
    input  logic [7:0]      i_clip_mask,
    output logic [FB_W-1:0] o_new_row,
    output logic            o_hit
);

    logic [FB_W-1:0] w_sprite_row;

    // The 6-bit column sum wraps naturally, giving the horizontal mod-64 wrap.
    always_comb begin
        w_sprite_row = '0;
        for (int k = 0; k < 8; k++) begin
            w_sprite_row[6'(i_x + 6'(k))] = i_byte[3'(7 - k)] & i_clip_mask[3'(k)];
        end
    end

    assign o_new_row = i_old_row ^ w_sprite_row;
    assign o_hit     = |(i_old_row & w_sprite_row);

endmodule

// File: rtl/chip8_sprite_drawer.sv
// Chip8 framebuffer write side: owns the 64x32 framebuffer, executes DRW
// (fetch n sprite bytes, XOR into framebuffer with collision detect) and CLS
// (clear one row per cycle). One command at a time; done pulses at completion.
// Optional build macro: CHIP8_SPRITE_CLIP_EN - pixels past the right or
// bottom edge are dropped instead of wrapping (fetch timing is unchanged).
// Ports:
//   clk50, reset          clock, synchronous active-high reset
//   draw_start            DRW request (sampled in IDLE)
//   clear_start           CLS request (sampled in IDLE, wins over draw)
//   sprite_x/y/n          Vx, Vy, sprite height
//   index_i               I register, sprite base address
//   mem_addr, mem_rd_data sprite memory port, data valid one cycle later
//   framebuffer           2048 bits, bit row*64+col
//   busy, done, collision status; collision is VF
module chip8_sprite_drawer
    import chip8_fb_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                clk50,
    input  logic                reset,
    input  logic                draw_start,
    input  logic                clear_start,
    input  logic [7:0]          sprite_x,
    input  logic [7:0]          sprite_y,
    input  logic [3:0]          sprite_n,
    input  logic [ADDR_W-1:0]   index_i,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [7:0]          mem_rd_data,
    output logic [FB_BITS-1:0]  framebuffer,
    output logic                busy,
    output logic                done,
    output logic                collision
);

    state_t             r_state;
    state_t             w_next;
    logic [5:0]         r_x;
    logic [4:0]         r_y;
    logic [3:0]         r_n;
    logic [3:0]         r_row_cnt;
    logic [ADDR_W-1:0]  r_index;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [4:0]         r_clr_row;
    logic               r_collision;
    logic [FB_BITS-1:0] r_fb;

    logic [4:0]         w_row;
    logic [FB_W-1:0]    w_old_row;
    logic [FB_W-1:0]    w_new_row;
    logic               w_hit;
    logic [7:0]         w_clip_mask;
    logic               w_last_row;
    logic               w_unused_bits;

    // Only the low bits of Vx/Vy matter once reduced mod 64 / mod 32.
    assign w_unused_bits = ^{sprite_x[7:6], sprite_y[7:5]};

    // 5-bit sum wraps the target row mod 32.
    assign w_row      = 5'(r_y + 5'(r_row_cnt));
    assign w_old_row  = r_fb[fb_index(w_row, 6'd0) +: FB_W];
    assign w_last_row = (5'(r_row_cnt) + 5'd1) >= {1'b0, r_n};

`ifdef CHIP8_SPRITE_CLIP_EN
    logic [5:0] w_row_sum;
    assign w_row_sum = {1'b0, r_y} + {2'b0, r_row_cnt};

    // A row past the bottom edge is still fetched but writes nothing.
    always_comb begin
        w_clip_mask = '0;
        for (int k = 0; k < 8; k++) begin
            w_clip_mask[3'(k)] = !w_row_sum[5] && ((7'(r_x) + 7'(k)) < 7'd64);
        end
    end
`else
    assign w_clip_mask = 8'hFF;
`endif

    chip8_row_xor u_row_xor (
        .i_old_row   (w_old_row),
        .i_byte      (mem_rd_data),
        .i_x         (r_x),
        .i_clip_mask (w_clip_mask),
        .o_new_row   (w_new_row),
        .o_hit       (w_hit)
    );

    always_ff @(posedge clk50) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (clear_start)     w_next = S_CLEAR;
                else if (draw_start) w_next = (sprite_n == 4'd0) ? S_DONE : S_FETCH;
            end
            S_FETCH: w_next = S_DRAW;
            S_DRAW:  w_next = w_last_row ? S_DONE : S_FETCH;
            S_CLEAR: w_next = (r_clr_row == 5'd31) ? S_DONE : S_CLEAR;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_fb        <= '0;
            r_mem_addr  <= '0;
            r_collision <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_n         <= '0;
            r_row_cnt   <= '0;
            r_index     <= '0;
            r_clr_row   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear_start) begin
                        r_clr_row <= '0;
                    end else if (draw_start) begin
                        r_x         <= sprite_x[5:0];
                        r_y         <= sprite_y[4:0];
                        r_n         <= sprite_n;
                        r_index     <= index_i;
                        r_row_cnt   <= '0;
                        r_collision <= 1'b0;
                        // Present row 0's address already during the first FETCH.
                        r_mem_addr  <= index_i;
                    end
                end
                S_DRAW: begin
                    r_fb[fb_index(w_row, 6'd0) +: FB_W] <= w_new_row;
                    r_collision <= r_collision | w_hit;
                    r_row_cnt   <= r_row_cnt + 4'd1;
                    r_mem_addr  <= r_index + ADDR_W'(r_row_cnt) + ADDR_W'(1);
                end
                S_CLEAR: begin
                    r_fb[fb_index(r_clr_row, 6'd0) +: FB_W] <= '0;
                    r_clr_row <= r_clr_row + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr    = r_mem_addr;
    assign framebuffer = r_fb;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign collision   = r_collision;

endmodule

// File: tb/tb_chip8_sprite_drawer.sv
module tb_chip8_sprite_drawer;
    import chip8_fb_pkg::*;

    logic               clk50 = 1'b0;
    logic               reset;
    logic               draw_start;
    logic               clear_start;
    logic [7:0]         sprite_x;
    logic [7:0]         sprite_y;
    logic [3:0]         sprite_n;
    logic [11:0]        index_i;
    logic [11:0]        mem_addr;
    logic [7:0]         mem_rd_data;
    logic [FB_BITS-1:0] framebuffer;
    logic               busy;
    logic               done;
    logic               collision;

    logic [7:0]         mem [0:4095];
    logic [FB_BITS-1:0] exp_fb;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk50 = ~clk50;

    // Synchronous sprite memory: data valid one cycle after the address.
    always @(posedge clk50) mem_rd_data <= mem[mem_addr];

    chip8_sprite_drawer dut (
        .clk50       (clk50),
        .reset       (reset),
        .draw_start  (draw_start),
        .clear_start (clear_start),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .sprite_n    (sprite_n),
        .index_i     (index_i),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .framebuffer (framebuffer),
        .busy        (busy),
        .done        (done),
        .collision   (collision)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic px(input int row, input int col);
        exp_fb[row * 64 + col] = ~exp_fb[row * 64 + col];
    endtask

    function automatic logic [63:0] fb_diff();
        return 64'($countones(framebuffer ^ exp_fb));
    endfunction

    // Issue one command; lat = cycles after the start edge until done is seen
    // (0 means done during the cycle right after the start edge).
    task automatic run_cmd(input logic drw, input logic cls, input logic [7:0] x, input logic [7:0] y,
                           input logic [3:0] n, input logic [11:0] idx,
                           output int lat, output int busy_cnt,
                           output logic [11:0] a0, output logic [11:0] a1);
        draw_start  = drw;
        clear_start = cls;
        sprite_x    = x;
        sprite_y    = y;
        sprite_n    = n;
        index_i     = idx;
        tick();
        draw_start  = 1'b0;
        clear_start = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        a0       = '0;
        a1       = '0;
        for (int c = 0; c < 100; c++) begin
            if (busy) busy_cnt++;
            if (c == 0) a0 = mem_addr;
            if (c == 2) a1 = mem_addr;
            if (done) begin
                lat = c;
                break;
            end
            tick();
        end
        tick();
    endtask

    int          lat;
    int          bcnt;
    int          done_cnt;
    logic [11:0] a0;
    logic [11:0] a1;
    logic [11:0] addr_before;

    initial begin
        reset       = 1'b1;
        draw_start  = 1'b0;
        clear_start = 1'b0;
        sprite_x    = '0;
        sprite_y    = '0;
        sprite_n    = '0;
        index_i     = '0;
        exp_fb      = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h200] = 8'hF0;
        mem[12'h300] = 8'hFF;
        mem[12'h301] = 8'h81;
        mem[12'h400] = 8'h80;
        mem[12'hFFF] = 8'h01;
        mem[12'h500] = 8'hF0;
        mem[12'h501] = 8'h0F;
        mem[12'h502] = 8'hFF;
        mem[12'h503] = 8'hAA;

        // 1: reset state
        repeat (3) tick();
        check_eq("rst fb", fb_diff(), 64'd0);
        check_eq("rst busy", 64'(busy), 64'd0);
        check_eq("rst done", 64'(done), 64'd0);
        check_eq("rst collision", 64'(collision), 64'd0);
        check_eq("rst mem_addr", 64'(mem_addr), 64'd0);
        reset = 1'b0;
        tick();

        // 2: single row F0 at origin
        run_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd1, 12'h200, lat, bcnt, a0, a1);
        px(0, 0); px(0, 1); px(0, 2); px(0, 3);
        check_eq("t2 fetch addr", 64'(a0), 64'h200);
        check_eq("t2 latency", 64'(lat), 64'd2);
        check_eq("t2 busy cycles", 64'(bcnt), 64'd3);
        check_eq("t2 fb", fb_diff(), 64'd0);
        check_eq("t2 fb low", framebuffer[63:0], 64'hF);
        check_eq("t2 collision", 64'(collision), 64'd0);
        check_eq("t2 idle busy", 64'(busy), 64'd0);
        check_eq("t2 idle done", 64'(done), 64'd0);

        // 3: same draw erases and collides
        run_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd1, 12'h200, lat, bcnt, a0, a1);
        px(0, 0); px(0, 1); px(0, 2); px(0, 3);
        check_eq("t3 latency", 64'(lat), 64'd2);
        check_eq("t3 fb", fb_diff(), 64'd0);
        check_eq("t3 collision", 64'(collision), 64'd1);

        // 4: bottom-right corner, wraps (or clips)
        run_cmd(1'b1, 1'b0, 8'd62, 8'd31, 4'd2, 12'h300, lat, bcnt, a0, a1);
`ifdef CHIP8_SPRITE_CLIP_EN
        px(31, 62); px(31, 63);
`else
        px(31, 62); px(31, 63);
        for (int c = 0; c < 6; c++) px(31, c);
        px(0, 62); px(0, 5);
`endif
        check_eq("t4 addr row0", 64'(a0), 64'h300);
        check_eq("t4 addr row1", 64'(a1), 64'h301);
        check_eq("t4 latency", 64'(lat), 64'd4);
        check_eq("t4 fb", fb_diff(), 64'd0);
        check_eq("t4 collision", 64'(collision), 64'd0);

        // 4b: overlapping draw raises collision before the clear
        run_cmd(1'b1, 1'b0, 8'd62, 8'd31, 4'd1, 12'h200, lat, bcnt, a0, a1);
`ifdef CHIP8_SPRITE_CLIP_EN
        px(31, 62); px(31, 63);
`else
        px(31, 62); px(31, 63); px(31, 0); px(31, 1);
`endif
        check_eq("t4b fb", fb_diff(), 64'd0);
        check_eq("t4b collision", 64'(collision), 64'd1);

        // 5: clear wins over draw
        addr_before = mem_addr;
        run_cmd(1'b1, 1'b1, 8'd0, 8'd0, 4'd3, 12'h400, lat, bcnt, a0, a1);
        exp_fb = '0;
        check_eq("t5 latency", 64'(lat), 64'd32);
        check_eq("t5 busy cycles", 64'(bcnt), 64'd33);
        check_eq("t5 fb", fb_diff(), 64'd0);
        check_eq("t5 no fetch", 64'(mem_addr), 64'(addr_before));
        check_eq("t5 collision kept", 64'(collision), 64'd1);

        // 6: n=0, coordinate reduction, address wrap
        run_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'h200, lat, bcnt, a0, a1);
        check_eq("t6 n0 latency", 64'(lat), 64'd0);
        check_eq("t6 n0 busy cycles", 64'(bcnt), 64'd1);
        check_eq("t6 n0 collision", 64'(collision), 64'd0);
        check_eq("t6 n0 fb", fb_diff(), 64'd0);

        run_cmd(1'b1, 1'b0, 8'd200, 8'd40, 4'd1, 12'h400, lat, bcnt, a0, a1);
        px(8, 8);
        check_eq("t6 mod latency", 64'(lat), 64'd2);
        check_eq("t6 mod pixel", 64'(framebuffer[520]), 64'd1);
        check_eq("t6 mod fb", fb_diff(), 64'd0);

        run_cmd(1'b1, 1'b0, 8'd10, 8'd3, 4'd2, 12'hFFF, lat, bcnt, a0, a1);
        px(3, 17);
        check_eq("t6 wrap addr0", 64'(a0), 64'hFFF);
        check_eq("t6 wrap addr1", 64'(a1), 64'h000);
        check_eq("t6 wrap latency", 64'(lat), 64'd4);
        check_eq("t6 wrap fb", fb_diff(), 64'd0);

        // 7: reset in the middle of a 4-row draw
        draw_start = 1'b1;
        sprite_x   = 8'd0;
        sprite_y   = 8'd0;
        sprite_n   = 4'd4;
        index_i    = 12'h500;
        tick();
        draw_start = 1'b0;
        repeat (4) tick();
        check_eq("t7 row0 drawn", framebuffer[63:0], 64'hF);
        check_eq("t7 busy mid", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_fb = '0;
        check_eq("t7 busy", 64'(busy), 64'd0);
        check_eq("t7 fb", fb_diff(), 64'd0);
        check_eq("t7 mem_addr", 64'(mem_addr), 64'd0);
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) done_cnt++;
            tick();
        end
        check_eq("t7 no done", 64'(done_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
